uart_write_loader: RTL and testbench
====================================

UART_WRITE_LOADER -- requirements
Module: uart_write_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 200000; maximum idle clocks between two bytes of one packet.
REQ-002 Parameter HEADER, default 8'hA5; packet start byte.
REQ-003 Parameter ACK, default 8'h06; NAK, default 8'h15; response bytes.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx_data  input  8  received byte from UART PHY; valid only when rx_ready=1.
REQ-007 rx_ready  input  1  one-cycle strobe per received byte.
REQ-008 tx_data  output  8  byte handed to UART PHY transmitter.
REQ-009 tx_req  output  1  one-cycle transmit request.
REQ-010 tx_busy  input  1  PHY transmitter busy.
REQ-011 mem_req  output  1  write request to system bus.
REQ-012 mem_addr  output  32  write address.
REQ-013 mem_wdata  output  32  write data.
REQ-014 mem_be  output  4  byte enables; always 4'hF while mem_req=1.
REQ-015 mem_gnt  input  1  bus accepts the write in a cycle where mem_req=1 and mem_gnt=1.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 err_timeout  output  1  one-cycle pulse on inter-byte timeout.

Function
REQ-018 Packet format: HEADER, 4 address bytes LSB first, 4 data bytes LSB first, 1 checksum byte; 10 bytes total.
REQ-019 Checksum is the 8-bit XOR of the 8 address and data bytes; the header is excluded.
REQ-020 States: IDLE, ADDR, DATA, CHK, WRITE, RESP_WAIT, RESP.
REQ-021 IDLE: rx_ready with rx_data==HEADER -> ADDR; any other byte is silently discarded.
REQ-022 ADDR: 4 bytes shift into the address register, LSB first, and update the running checksum; after the 4th byte -> DATA.
REQ-023 DATA: same for 4 data bytes; after the 4th byte -> CHK.
REQ-024 CHK: on the received byte, match -> WRITE; mismatch -> RESP_WAIT with the response set to NAK and no bus access.
REQ-025 WRITE: mem_req=1 with mem_addr, mem_wdata and mem_be stable until the grant cycle; on mem_gnt=1 -> RESP_WAIT with the response set to ACK, and mem_req is low from the next cycle.
REQ-026 WRITE has no timeout; mem_req holds indefinitely until granted.
REQ-027 RESP_WAIT: when tx_busy=0 -> RESP.
REQ-028 RESP: tx_req=1 for exactly one cycle with tx_data=response; next state IDLE.
REQ-029 rx_ready strobes in WRITE, RESP_WAIT or RESP are ignored; they do not start a new packet.
REQ-030 Timeout counter runs in ADDR, DATA and CHK, and clears on each accepted byte.
REQ-031 When the counter reaches TIMEOUT_CYCLES: pulse err_timeout, discard the packet, return to IDLE, send no response.
REQ-032 A HEADER-valued byte inside a packet is treated as payload, not as a resync.
REQ-033 Checksum register and byte counter clear on entry to ADDR.
REQ-034 At most one mem_req and one tx_req per packet.

Reset
REQ-035 While rst=1 the next state is IDLE, and tx_req, mem_req, busy and err_timeout are 0.
REQ-036 Reset also clears mem_addr, mem_wdata, tx_data, checksum, byte counter and timeout counter to 0.
REQ-037 rst asserted mid-packet or mid-WRITE drops the transaction with no response; mem_req is low the cycle after reset is sampled.

Verification
REQ-038 Bytes A5 10 00 00 00 EF BE AD DE 32 -> one write: mem_addr=32'h00000010, mem_wdata=32'hDEADBEEF, mem_be=4'hF; then a single tx_req with tx_data=8'h06.
REQ-039 Same packet with checksum 33 -> no mem_req; a single tx_req with tx_data=8'h15.
REQ-040 Bytes 00 FF then the valid packet -> the leading bytes are ignored and the result matches REQ-038.
REQ-041 mem_gnt delayed 5 cycles -> mem_req and address/data held stable for 5 cycles; ACK is sent only after the grant.
REQ-042 tx_busy held high 100 cycles at the response point -> tx_req is issued only after tx_busy falls.
REQ-043 A5 01 02 then silence for TIMEOUT_CYCLES -> one err_timeout pulse, busy=0, no tx_req; a following valid packet is processed normally.

Source files
------------

// File: rtl/uart_write_loader.sv
// UART packet loader: receives header/address/data/checksum frames and issues one
// 32-bit bus write per valid frame, answering each checked frame with ACK or NAK.
module uart_write_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter logic [7:0]  ACK            = 8'h06,
  parameter logic [7:0]  NAK            = 8'h15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_req,
  input  logic        tx_busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  output logic        busy,
  output logic        err_timeout
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_WRITE,
    S_RESP_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       chk;
  logic [1:0]       byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_expired;
  logic             timeout_hit;

  // Fires on the TIMEOUT_CYCLES-th consecutive clock without an accepted byte.
  assign tmo_expired = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_ready && (rx_data == HEADER)) state_next = S_ADDR;
      end
      S_ADDR: begin
        if (rx_ready) begin
          if (byte_cnt == 2'd3) state_next = S_DATA;
        end else if (tmo_expired) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_ready) begin
          if (byte_cnt == 2'd3) state_next = S_CHK;
        end else if (tmo_expired) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_CHK: begin
        if (rx_ready) begin
          state_next = (rx_data == chk) ? S_WRITE : S_RESP_WAIT;
        end else if (tmo_expired) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_WRITE: begin
        if (mem_gnt) state_next = S_RESP_WAIT;
      end
      S_RESP_WAIT: begin
        if (!tx_busy) state_next = S_RESP;
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (rst) begin
      state_next  = S_IDLE;
      timeout_hit = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_be      <= 4'h0;
      tx_req      <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      tx_data     <= '0;
      chk         <= '0;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
    end else begin
      mem_req     <= (state_next == S_WRITE);
      mem_be      <= (state_next == S_WRITE) ? 4'hF : 4'h0;
      tx_req      <= (state_next == S_RESP);
      busy        <= (state_next != S_IDLE);
      err_timeout <= timeout_hit;
      case (state)
        S_IDLE: begin
          tmo_cnt <= '0;
          if (rx_ready && (rx_data == HEADER)) begin
            chk      <= '0;
            byte_cnt <= '0;
          end
        end
        S_ADDR: begin
          if (rx_ready) begin
            mem_addr <= {rx_data, mem_addr[31:8]};
            chk      <= chk ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt  <= tmo_cnt + TMO_W'(1);
          end
        end
        S_DATA: begin
          if (rx_ready) begin
            mem_wdata <= {rx_data, mem_wdata[31:8]};
            chk       <= chk ^ rx_data;
            byte_cnt  <= byte_cnt + 2'd1;
            tmo_cnt   <= '0;
          end else begin
            tmo_cnt   <= tmo_cnt + TMO_W'(1);
          end
        end
        S_CHK: begin
          if (rx_ready) begin
            tmo_cnt <= '0;
            if (rx_data != chk) tx_data <= NAK;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_WRITE: begin
          tmo_cnt <= '0;
          if (mem_gnt) tx_data <= ACK;
        end
        default: begin
          tmo_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_write_loader.sv
// Bench for uart_write_loader: table of frames plus hand sequences for timeout,
// reset and ignored-strobe cases; bus writes and responses checked via scoreboard queues.
module tb_uart_write_loader;

  localparam int unsigned TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic        tx_busy = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        busy;
  logic        err_timeout;

  uart_write_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_req(tx_req), .tx_busy(tx_busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string       name;
    int unsigned n;
    logic [95:0] bytes;     // frame bytes left-aligned, first byte in [95:88]
    logic        exp_write;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [7:0]  exp_resp;
    int unsigned gnt_delay;
    int unsigned busy_hold;
  } vec_t;

  wr_t        mem_q[$];
  logic [7:0] tx_q[$];
  vec_t       vecs[7];
  wr_t        mon_w;
  logic [7:0] mon_b;
  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int tx_cnt = 0;
  int tmo_pulses = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic wait_mem_req(input string nm, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check({nm, "_mem_req_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) check({nm, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  // Scoreboard: pop expected write / response whenever the DUT produces one.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_gnt) begin
        wr_cnt++;
        if (mem_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          mon_w = mem_q.pop_front();
          check("wr_addr", mem_addr, mon_w.addr);
          check("wr_data", mem_wdata, mon_w.data);
          check("wr_be", 32'(mem_be), 32'hF);
        end
      end
      if (tx_req) begin
        tx_cnt++;
        if (tx_q.size() == 0) check("unexpected_tx", 32'd1, 32'd0);
        else begin
          mon_b = tx_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(mon_b));
        end
      end
      if (err_timeout) tmo_pulses++;
    end
  end

  task automatic run_vec(input vec_t v);
    logic [95:0] pk;
    wr_t w;
    int tx0, wr0;
    bit ok;
    pk  = v.bytes;
    tx0 = tx_cnt;
    wr0 = wr_cnt;
    if (v.exp_write) begin
      w.addr = v.exp_addr;
      w.data = v.exp_data;
      mem_q.push_back(w);
    end
    tx_q.push_back(v.exp_resp);
    tx_busy = (v.busy_hold != 0);
    for (int i = 0; i < int'(v.n); i++) begin
      send_byte(pk[95:88]);
      pk = pk << 8;
    end
    if (v.exp_write) begin
      wait_mem_req(v.name, ok);
      if (ok) begin
        for (int d = 0; d < int'(v.gnt_delay); d++) begin
          check({v.name, "_hold_req"}, 32'(mem_req), 32'd1);
          check({v.name, "_hold_addr"}, mem_addr, v.exp_addr);
          check({v.name, "_hold_data"}, mem_wdata, v.exp_data);
          check({v.name, "_no_tx_before_gnt"}, 32'(tx_cnt - tx0), 32'd0);
          tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check({v.name, "_req_drop"}, 32'(mem_req), 32'd0);
      end
    end
    if (v.busy_hold != 0) begin
      repeat (v.busy_hold) tick();
      check({v.name, "_no_tx_while_busy"}, 32'(tx_cnt - tx0), 32'd0);
      tx_busy = 1'b0;
    end
    wait_idle(v.name);
    tick();
    check({v.name, "_tx_count"}, 32'(tx_cnt - tx0), 32'd1);
    check({v.name, "_wr_count"}, 32'(wr_cnt - wr0), 32'(v.exp_write));
  endtask

  initial begin
    bit ok;
    bit seen;
    int lat;
    int tx0, wr0, p0;
    wr_t w;

    vecs[0] = '{"valid", 10, 96'hA5_10_00_00_00_EF_BE_AD_DE_32_00_00, 1'b1,
                32'h0000_0010, 32'hDEAD_BEEF, 8'h06, 0, 0};
    vecs[1] = '{"bad_chk", 10, 96'hA5_10_00_00_00_EF_BE_AD_DE_33_00_00, 1'b0,
                32'h0, 32'h0, 8'h15, 0, 0};
    vecs[2] = '{"junk_lead", 12, 96'h00_FF_A5_10_00_00_00_EF_BE_AD_DE_32, 1'b1,
                32'h0000_0010, 32'hDEAD_BEEF, 8'h06, 0, 0};
    vecs[3] = '{"gnt_delay5", 10, 96'hA5_10_00_00_00_EF_BE_AD_DE_32_00_00, 1'b1,
                32'h0000_0010, 32'hDEAD_BEEF, 8'h06, 5, 0};
    vecs[4] = '{"tx_busy100", 10, 96'hA5_10_00_00_00_EF_BE_AD_DE_32_00_00, 1'b1,
                32'h0000_0010, 32'hDEAD_BEEF, 8'h06, 0, 100};
    vecs[5] = '{"hdr_payload", 10, 96'hA5_A5_A5_A5_A5_01_02_03_04_04_00_00, 1'b1,
                32'hA5A5_A5A5, 32'h0403_0201, 8'h06, 0, 0};
    vecs[6] = '{"bad_chk_hdr", 10, 96'hA5_78_56_34_12_44_33_22_11_A5_00_00, 1'b0,
                32'h0, 32'h0, 8'h15, 2, 0};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    tick();

    // A second valid frame with distinct payload
    vecs[6].exp_write = 1'b0;
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    vecs[6] = '{"valid2", 10, 96'hA5_78_56_34_12_44_33_22_11_4C_00_00, 1'b1,
                32'h1234_5678, 32'h1122_3344, 8'h06, 2, 0};
    run_vec(vecs[6]);

    // Inter-byte timeout
    tx0 = tx_cnt;
    p0  = tmo_pulses;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    seen = 1'b0;
    lat  = 0;
    for (int k = 0; k < int'(TMO) + 20; k++) begin
      tick();
      if (err_timeout) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
    check("tmo_pulse_seen", 32'(seen), 32'd1);
    check("tmo_latency", 32'(lat >= int'(TMO) - 3 && lat <= int'(TMO) + 2), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check("tmo_single_pulse", 32'(tmo_pulses - p0), 32'd1);
    check("tmo_no_tx", 32'(tx_cnt - tx0), 32'd0);
    run_vec(vecs[0]);

    // Reset mid-packet, then a clean frame must still check correctly
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h77);
    rst = 1'b1;
    tick();
    check("rstpkt_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    run_vec(vecs[5]);

    // Reset mid-WRITE drops the transaction silently
    tx0 = tx_cnt;
    wr0 = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      logic [95:0] pk;
      pk = vecs[0].bytes << (8 * i);
      send_byte(pk[95:88]);
    end
    wait_mem_req("rstwr", ok);
    rst = 1'b1;
    tick();
    check("rstwr_req_low", 32'(mem_req), 32'd0);
    check("rstwr_busy", 32'(busy), 32'd0);
    check("rstwr_addr", mem_addr, 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("rstwr_no_tx", 32'(tx_cnt - tx0), 32'd0);
    check("rstwr_no_wr", 32'(wr_cnt - wr0), 32'd0);

    // Strobes during RESP_WAIT must not open a new frame
    tx0 = tx_cnt;
    w.addr = 32'h0000_0010;
    w.data = 32'hDEAD_BEEF;
    mem_q.push_back(w);
    tx_q.push_back(8'h06);
    tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [95:0] pk;
      pk = vecs[0].bytes << (8 * i);
      send_byte(pk[95:88]);
    end
    wait_mem_req("ign", ok);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h00);
    tx_busy = 1'b0;
    wait_idle("ign");
    repeat (3) tick();
    check("ign_busy", 32'(busy), 32'd0);
    check("ign_tx_count", 32'(tx_cnt - tx0), 32'd1);

    repeat (3) tick();
    check("tmo_total", 32'(tmo_pulses), 32'd1);
    check("mem_q_empty", 32'(mem_q.size()), 32'd0);
    check("tx_q_empty", 32'(tx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
